// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU control path.
// Holds the execute-state encodings consumed by the output-signal decoder,
// the instruction class codes and the bit positions of the instruction fields,
// so the sequencer and the decoder agree on one definition.
package cpu_pkg;

    localparam int OPW  = 23;
    localparam int STW  = 5;
    localparam int CNTW = 16;

    // State codes driven to the output decoder on the state bus.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00000,
        ST_LOAD   = 5'b00001,
        ST_MOV    = 5'b00010,
        ST_ALU_A  = 5'b00011,
        ST_ALU_B  = 5'b00100,
        ST_ALU_WB = 5'b00101,
        ST_BRANCH = 5'b00110,
        ST_HALT   = 5'b00111,
        ST_FETCH  = 5'b01000
    } state_t;

    // Instruction class codes (instr[22:20]); 101 and 110 are undefined.
    localparam logic [2:0] CLS_NOP    = 3'b000;
    localparam logic [2:0] CLS_LOAD   = 3'b001;
    localparam logic [2:0] CLS_MOV    = 3'b010;
    localparam logic [2:0] CLS_ALU    = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b100;
    localparam logic [2:0] CLS_HALT   = 3'b111;

    // Instruction field bit positions.
    localparam int CLS_MSB = 22;
    localparam int CLS_LSB = 20;
    localparam int RD_MSB  = 19;
    localparam int RD_LSB  = 16;
    localparam int RS_MSB  = 15;
    localparam int RS_LSB  = 12;
    localparam int IMM_MSB = 11;
    localparam int IMM_LSB = 0;

    // Field extraction helpers for blocks that consume the latched opcode.
    function automatic logic [2:0] instr_class(input logic [22:0] word);
        return word[CLS_MSB:CLS_LSB];
    endfunction

    function automatic logic [3:0] instr_rd(input logic [22:0] word);
        return word[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [3:0] instr_rs(input logic [22:0] word);
        return word[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [11:0] instr_imm(input logic [22:0] word);
        return word[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/instr_latch.sv
// Opcode register plus class extraction for the control sequencer.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load       - capture instr into opcode on this edge
//   instr      - instruction word arriving from memory
//   opcode     - latched instruction, stable until the next load
//   instr_cls  - class field of the incoming word, used for dispatch in the
//                same cycle the word is captured
module instr_latch
    import cpu_pkg::*;
#(
    parameter int OPW = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [OPW-1:0] instr,
    output logic [OPW-1:0] opcode,
    output logic [2:0]     instr_cls
);

    // The opcode only changes on an accepted fetch, so the decoder sees a
    // stable word for the whole execute sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode <= '0;
        end else if (load) begin
            opcode <= instr;
        end
    end

    // Dispatch must look at the word being accepted, not the previous opcode.
    assign instr_cls = instr[CLS_MSB:CLS_LSB];

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer for the simple CPU.
// Fetches an instruction over a req/valid handshake, latches it as opcode and
// walks the execute-state codes that the output decoder turns into bus
// controls, then returns to fetch.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   run          - leave IDLE and start fetching
//   hold         - stall; freezes state, opcode and retired count
//   instr        - instruction word from memory
//   instr_valid  - instr is valid this cycle
//   instr_req    - fetch request to memory (combinational)
//   state        - current state code to the output decoder
//   opcode       - latched instruction to the output decoder
//   busy         - not in IDLE or HALT (combinational)
//   halted       - HALT reached
//   illegal      - one-cycle pulse after dispatching an undefined class
//   retired      - count of completed instructions, wraps
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW  = 23,
    parameter int STW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            hold,
    input  logic [OPW-1:0]  instr,
    input  logic            instr_valid,
    output logic            instr_req,
    output logic [STW-1:0]  state,
    output logic [OPW-1:0]  opcode,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] retired
);

    state_t     state_q;
    state_t     state_d;
    logic       fetch_fire;
    logic       retire;
    logic       bad_class;
    logic [2:0] instr_cls;

    instr_latch #(
        .OPW(OPW)
    ) u_instr_latch (
        .clk       (clk),
        .rst       (rst),
        .load      (fetch_fire),
        .instr     (instr),
        .opcode    (opcode),
        .instr_cls (instr_cls)
    );

    // Next-state logic. Everything is gated by hold so a stall freezes the
    // machine exactly where it is; retire marks the cycle that completes an
    // instruction (last execute cycle, or the dispatch cycle for NOP/undefined).
    always_comb begin
        state_d    = state_q;
        fetch_fire = 1'b0;
        retire     = 1'b0;
        bad_class  = 1'b0;
        if (!hold) begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (instr_valid) begin
                        fetch_fire = 1'b1;
                        case (instr_cls)
                            CLS_NOP: begin
                                state_d = ST_FETCH;
                                retire  = 1'b1;
                            end
                            CLS_LOAD:   state_d = ST_LOAD;
                            CLS_MOV:    state_d = ST_MOV;
                            CLS_ALU:    state_d = ST_ALU_A;
                            CLS_BRANCH: state_d = ST_BRANCH;
                            CLS_HALT:   state_d = ST_HALT;
                            default: begin
                                state_d   = ST_FETCH;
                                retire    = 1'b1;
                                bad_class = 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD, ST_MOV, ST_BRANCH: begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
                ST_ALU_A:  state_d = ST_ALU_B;
                ST_ALU_B:  state_d = ST_ALU_WB;
                ST_ALU_WB: begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
                ST_HALT:   state_d = ST_HALT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State register and registered status outputs. halted tracks the next
    // state so it rises together with the HALT state code; illegal is only
    // ever set by a real dispatch, so a hold cannot stretch or repeat it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            retired <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired <= retired + CNTW'(1);
            end
            halted  <= (state_d == ST_HALT);
            illegal <= bad_class;
        end
    end

    assign state     = STW'(state_q);
    assign instr_req = (state_q == ST_FETCH) && !hold;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Each step drives the inputs for one
// cycle and pushes the outputs expected after the next rising edge into a
// scoreboard queue; the entry is popped and compared once that edge has passed.
module tb_control_sequencer;

    localparam logic [4:0] S_IDLE   = 5'b00000;
    localparam logic [4:0] S_LOAD   = 5'b00001;
    localparam logic [4:0] S_MOV    = 5'b00010;
    localparam logic [4:0] S_ALU_A  = 5'b00011;
    localparam logic [4:0] S_ALU_B  = 5'b00100;
    localparam logic [4:0] S_ALU_WB = 5'b00101;
    localparam logic [4:0] S_BRANCH = 5'b00110;
    localparam logic [4:0] S_HALT   = 5'b00111;
    localparam logic [4:0] S_FETCH  = 5'b01000;

    typedef struct {
        string       tag;
        logic [4:0]  st;
        logic [22:0] op;
        logic [15:0] ret;
        logic        req;
        logic        bsy;
        logic        hlt;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        hold;
    logic [22:0] instr;
    logic        instr_valid;
    logic        instr_req;
    logic [4:0]  state;
    logic [22:0] opcode;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    exp_t sb[$];
    int   checks;
    int   passes;

    control_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .hold        (hold),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .state       (state),
        .opcode      (opcode),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison through an immediate assertion.
    task automatic compare(input string tag, input string field,
                           input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, away from the rising edge.
    task automatic apply_stimulus(input logic r, input logic h, input logic rn,
                                  input logic v, input logic [22:0] in);
        @(negedge clk);
        rst         = r;
        hold        = h;
        run         = rn;
        instr_valid = v;
        instr       = in;
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("[TB] FAIL scoreboard empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            compare(e.tag, "state",     32'(state),     32'(e.st));
            compare(e.tag, "opcode",    32'(opcode),    32'(e.op));
            compare(e.tag, "retired",   32'(retired),   32'(e.ret));
            compare(e.tag, "instr_req", 32'(instr_req), 32'(e.req));
            compare(e.tag, "busy",      32'(busy),      32'(e.bsy));
            compare(e.tag, "halted",    32'(halted),    32'(e.hlt));
            compare(e.tag, "illegal",   32'(illegal),   32'(e.ill));
        end
    endtask

    // Full step: drive, record expectation, clock, compare. Expected
    // instr_req uses this step's hold, which stays applied while sampling.
    task automatic step(input string tag, input logic r, input logic h,
                        input logic rn, input logic v, input logic [22:0] in,
                        input logic [4:0] est, input logic [22:0] eop,
                        input logic [15:0] eret, input logic ehlt, input logic eill);
        exp_t e;
        apply_stimulus(r, h, rn, v, in);
        e.tag = tag;
        e.st  = est;
        e.op  = eop;
        e.ret = eret;
        e.req = (est == S_FETCH) && !h;
        e.bsy = (est != S_IDLE) && (est != S_HALT);
        e.hlt = ehlt;
        e.ill = eill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        rst         = 1'b1;
        hold        = 1'b0;
        run         = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;

        //     tag          rst  hold run  vld   instr        state     opcode       ret  hlt  ill
        step("reset0",     1'b1,1'b0,1'b0,1'b0, 23'h000000, S_IDLE,   23'h000000, 16'd0,1'b0,1'b0);
        step("reset1",     1'b1,1'b0,1'b1,1'b1, 23'h1A5000, S_IDLE,   23'h000000, 16'd0,1'b0,1'b0);
        step("idle",       1'b0,1'b0,1'b0,1'b1, 23'h1A5000, S_IDLE,   23'h000000, 16'd0,1'b0,1'b0);
        step("run",        1'b0,1'b0,1'b1,1'b0, 23'h000000, S_FETCH,  23'h000000, 16'd0,1'b0,1'b0);
        // LOAD: fetch, LOAD, back to fetch with retired=1.
        step("ld_fetch",   1'b0,1'b0,1'b0,1'b1, 23'h1A5000, S_LOAD,   23'h1A5000, 16'd0,1'b0,1'b0);
        step("ld_done",    1'b0,1'b0,1'b0,1'b0, 23'h000000, S_FETCH,  23'h1A5000, 16'd1,1'b0,1'b0);
        // ALU with valid held high: later words must not be latched.
        step("alu_fetch",  1'b0,1'b0,1'b0,1'b1, 23'h330000, S_ALU_A,  23'h330000, 16'd1,1'b0,1'b0);
        step("alu_b",      1'b0,1'b0,1'b0,1'b1, 23'h1A5000, S_ALU_B,  23'h330000, 16'd1,1'b0,1'b0);
        step("alu_wb",     1'b0,1'b0,1'b0,1'b1, 23'h1A5000, S_ALU_WB, 23'h330000, 16'd1,1'b0,1'b0);
        step("alu_done",   1'b0,1'b0,1'b0,1'b1, 23'h1A5000, S_FETCH,  23'h330000, 16'd2,1'b0,1'b0);
        // Memory delays valid for three cycles; request stays up.
        step("wait1",      1'b0,1'b0,1'b0,1'b0, 23'h212345, S_FETCH,  23'h330000, 16'd2,1'b0,1'b0);
        step("wait2",      1'b0,1'b0,1'b0,1'b0, 23'h212345, S_FETCH,  23'h330000, 16'd2,1'b0,1'b0);
        step("wait3",      1'b0,1'b0,1'b0,1'b0, 23'h212345, S_FETCH,  23'h330000, 16'd2,1'b0,1'b0);
        step("mov_fetch",  1'b0,1'b0,1'b0,1'b1, 23'h212345, S_MOV,    23'h212345, 16'd2,1'b0,1'b0);
        step("mov_done",   1'b0,1'b0,1'b0,1'b0, 23'h000000, S_FETCH,  23'h212345, 16'd3,1'b0,1'b0);
        // Hold for two cycles in ALU_B.
        step("h_fetch",    1'b0,1'b0,1'b0,1'b1, 23'h330ABC, S_ALU_A,  23'h330ABC, 16'd3,1'b0,1'b0);
        step("h_alu_b",    1'b0,1'b0,1'b0,1'b0, 23'h000000, S_ALU_B,  23'h330ABC, 16'd3,1'b0,1'b0);
        step("h_hold1",    1'b0,1'b1,1'b0,1'b0, 23'h000000, S_ALU_B,  23'h330ABC, 16'd3,1'b0,1'b0);
        step("h_hold2",    1'b0,1'b1,1'b0,1'b0, 23'h000000, S_ALU_B,  23'h330ABC, 16'd3,1'b0,1'b0);
        step("h_alu_wb",   1'b0,1'b0,1'b0,1'b0, 23'h000000, S_ALU_WB, 23'h330ABC, 16'd3,1'b0,1'b0);
        step("h_done",     1'b0,1'b0,1'b0,1'b0, 23'h000000, S_FETCH,  23'h330ABC, 16'd4,1'b0,1'b0);
        // Valid during hold in FETCH is ignored.
        step("f_hold",     1'b0,1'b1,1'b0,1'b1, 23'h500000, S_FETCH,  23'h330ABC, 16'd4,1'b0,1'b0);
        // Undefined class 101: one-cycle illegal, counted as retired.
        step("ill101",     1'b0,1'b0,1'b0,1'b1, 23'h500000, S_FETCH,  23'h500000, 16'd5,1'b0,1'b1);
        step("ill_clear",  1'b0,1'b0,1'b0,1'b0, 23'h000000, S_FETCH,  23'h500000, 16'd5,1'b0,1'b0);
        step("nop",        1'b0,1'b0,1'b0,1'b1, 23'h000123, S_FETCH,  23'h000123, 16'd6,1'b0,1'b0);
        step("ill110",     1'b0,1'b0,1'b0,1'b1, 23'h600000, S_FETCH,  23'h600000, 16'd7,1'b0,1'b1);
        step("br_fetch",   1'b0,1'b0,1'b0,1'b1, 23'h4000FF, S_BRANCH, 23'h4000FF, 16'd7,1'b0,1'b0);
        step("br_done",    1'b0,1'b0,1'b0,1'b0, 23'h000000, S_FETCH,  23'h4000FF, 16'd8,1'b0,1'b0);
        // HALT: sticky, ignores run and further valid words.
        step("halt",       1'b0,1'b0,1'b0,1'b1, 23'h700000, S_HALT,   23'h700000, 16'd8,1'b1,1'b0);
        step("halt_run",   1'b0,1'b0,1'b1,1'b1, 23'h1A5000, S_HALT,   23'h700000, 16'd8,1'b1,1'b0);
        step("halt_stay",  1'b0,1'b0,1'b1,1'b0, 23'h000000, S_HALT,   23'h700000, 16'd8,1'b1,1'b0);
        // Reset out of HALT, then reset again in the middle of an ALU op.
        step("rst_halt",   1'b1,1'b0,1'b0,1'b0, 23'h000000, S_IDLE,   23'h000000, 16'd0,1'b0,1'b0);
        step("run2",       1'b0,1'b0,1'b1,1'b0, 23'h000000, S_FETCH,  23'h000000, 16'd0,1'b0,1'b0);
        step("alu2",       1'b0,1'b0,1'b0,1'b1, 23'h330000, S_ALU_A,  23'h330000, 16'd0,1'b0,1'b0);
        step("rst_alu_a",  1'b1,1'b0,1'b0,1'b0, 23'h000000, S_IDLE,   23'h000000, 16'd0,1'b0,1'b0);
        // Hold also blocks leaving IDLE.
        step("idle_hold",  1'b0,1'b1,1'b1,1'b0, 23'h000000, S_IDLE,   23'h000000, 16'd0,1'b0,1'b0);
        step("idle_rel",   1'b0,1'b0,1'b1,1'b0, 23'h000000, S_FETCH,  23'h000000, 16'd0,1'b0,1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
